// File: rtl/usrt_tx_fifo.sv
// Buffered USRT transmitter: FIFO -> start/data/[parity]/stop frames on TXD with a derived bit clock.
// Optional parity bit and par_odd input are enabled by defining USRT_TX_PARITY_EN.
module usrt_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 2,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
`ifdef USRT_TX_PARITY_EN
   input  logic                          par_odd,
`endif
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          usrt_clk_o,
   output logic                          RTS,
   output logic                          TXD
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, SETUP, START, DATA, PARITY, STOP} state_t;

   state_t              state, state_n;
   logic [DIV_W-1:0]    div;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       count, count_n;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [DATA_W-1:0]   shift;
   logic                bit_end;
   logic                pop;
   logic                push;
`ifdef USRT_TX_PARITY_EN
   logic                par;
`endif

   // A full FIFO still accepts a write when the head leaves on the same edge
   assign push    = wr_en && (!full || pop);
   assign bit_end = (div == DIV_W'(CLK_DIV - 1));
   assign busy    = (state != IDLE);
   assign RTS     = (state != IDLE);
   assign level   = count;
   assign usrt_clk_o = busy && (div >= DIV_W'(CLK_DIV / 2));

   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_n;
         full  <= (count_n == LW'(FIFO_DEPTH));
         empty <= (count_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         div     <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         if (!busy || bit_end) div <= '0;
         else                  div <= div + 1'b1;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (start && !empty) state_n = SETUP;
         end
         SETUP: begin
            if (bit_end) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_cnt_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_n = '0;
`ifdef USRT_TX_PARITY_EN
                  state_n   = PARITY;
`else
                  state_n   = STOP;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               bit_cnt_n = '0;
               state_n   = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                  bit_cnt_n = '0;
                  // Back-to-back frames skip SETUP while the burst continues
                  if (start && !empty) begin
                     pop     = 1'b1;
                     state_n = START;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift <= mem[rd_ptr];
`ifdef USRT_TX_PARITY_EN
         par   <= (^mem[rd_ptr]) ^ par_odd;
`endif
      end else if (state == DATA && bit_end) begin
         shift <= shift >> 1;
      end
   end

   always_comb begin
      TXD = 1'b1;
      case (state)
         START:   TXD = 1'b0;
         DATA:    TXD = shift[0];
`ifdef USRT_TX_PARITY_EN
         PARITY:  TXD = par;
`endif
         default: TXD = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Scoreboard bench for usrt_tx_fifo: directed bursts plus randomized bursts against a frame-level model.
module tb_usrt_tx_fifo;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int CLK_DIV    = 2;
   localparam int STOP_BITS  = 1;
`ifdef USRT_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int FL = 1 + DATA_W + PBITS + STOP_BITS;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
`ifdef USRT_TX_PARITY_EN
   logic              par_odd = 1'b0;
`endif
   logic              full, empty, busy, usrt_clk_o, RTS, TXD;
   logic [LW-1:0]     level;

   typedef struct {
      logic [DATA_W-1:0] w;
      logic              odd;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   mcount = 0;

   always #5 clk = ~clk;

   usrt_tx_fifo #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .STOP_BITS(STOP_BITS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_data(wr_data),
`ifdef USRT_TX_PARITY_EN
      .par_odd(par_odd),
`endif
      .full(full), .empty(empty), .level(level), .busy(busy),
      .usrt_clk_o(usrt_clk_o), .RTS(RTS), .TXD(TXD)
   );

   // Bit idx of a frame: 0 start, 1..DATA_W data LSB first, then parity, then stop bits
   function automatic logic expected_bit(input exp_t e, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DATA_W) return e.w[idx-1];
`ifdef USRT_TX_PARITY_EN
      if (idx == DATA_W + 1) return (^e.w) ^ e.odd;
`endif
      return 1'b1;
   endfunction

   function automatic logic cur_odd();
`ifdef USRT_TX_PARITY_EN
      return par_odd;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      if (mcount < FIFO_DEPTH) begin
         sb.push_back('{d, cur_odd()});
         mcount++;
      end
      tick();
      wr_en = 1'b0;
   endtask

   // Cycle-exact check of n consecutive frames from the first start bit on
   task automatic check_burst(input int n, input int drop_k);
      exp_t e[$];
      int   w;
      int   fi;
      int   bi;
      if (sb.size() < n) begin
         chk("burst_model_depth", sb.size(), n);
         return;
      end
      for (int i = 0; i < n; i++) e.push_back(sb[i]);
      w = 0;
      while (TXD !== 1'b0 && w < 64) begin
         tick();
         w++;
      end
      if (w >= 64) begin
         chk("burst_start_timeout", w, 0);
         return;
      end
      for (int k = 0; k < n * FL * CLK_DIV; k++) begin
         fi = k / (FL * CLK_DIV);
         bi = (k / CLK_DIV) % FL;
         chk("txd_bit", TXD, expected_bit(e[fi], bi));
         chk("rts_burst", RTS, 1);
         chk("uclk_phase", usrt_clk_o, ((k % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0);
         if (k == drop_k) start = 1'b0;
         tick();
      end
      chk("rts_end", RTS, 0);
      chk("busy_end", busy, 0);
      chk("txd_idle", TXD, 1);
      chk("uclk_idle", usrt_clk_o, 0);
      mcount -= n;
   endtask

   // Monitor: decode frames at usrt_clk_o rises and compare with the scoreboard head
   initial begin : monitor
      logic [FL-1:0] got;
      logic [FL-1:0] expv;
      exp_t          e;
      int            idx;
      bit            in_frame;
      bit            prev;
      idx = 0;
      in_frame = 0;
      prev = 0;
      got = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            in_frame = 0;
            prev     = 0;
         end else begin
            if (usrt_clk_o === 1'b1 && !prev) begin
               if (!in_frame) begin
                  if (TXD === 1'b0) begin
                     in_frame = 1;
                     got      = '0;
                     idx      = 1;
                  end
               end else begin
                  got[idx] = TXD;
                  idx++;
                  if (idx == FL) begin
                     in_frame = 0;
                     vectors++;
                     if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame: got %h, expected no frame", got);
                     end else begin
                        e = sb.pop_front();
                        for (int i = 0; i < FL; i++) expv[i] = expected_bit(e, i);
                        if (got !== expv) begin
                           miscompares++;
                           $display("FAIL frame: got %h, expected %h (word %h)", got, expv, e.w);
                        end
                     end
                  end
               end
            end
            prev = (usrt_clk_o === 1'b1);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int w;
      int nw;
      int extra;
      int wat;
      int budget;
      int c;
      bit seen;
      bit done;

      // Reset with write attempts
      rst   = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'h3C;
      repeat (2) begin
         tick();
         chk("rst_txd", TXD, 1);
         chk("rst_rts", RTS, 0);
         chk("rst_uclk", usrt_clk_o, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_level", level, 0);
         chk("rst_busy", busy, 0);
      end
      wr_en = 1'b0;
      rst   = 1'b1;
      tick();

      // Single frame 0xA5
      push_word(8'hA5);
      chk("single_level", level, mcount);
      chk("single_empty", empty, 0);
      start = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) chk("rts_rise", RTS, 1);
      end while (TXD !== 1'b0 && lat < 20);
      chk("start_latency", lat, CLK_DIV + 1);
      check_burst(1, -1);

      // Back-to-back with start held
      push_word(8'h00);
      push_word(8'hFF);
      check_burst(2, -1);
      start = 1'b0;
      tick();

      // FIFO boundary
      for (int i = 0; i < 5; i++) begin
         push_word(DATA_W'(8'h11 * (i + 1)));
         chk("bound_level", level, mcount);
         chk("bound_full", full, (mcount == FIFO_DEPTH) ? 1 : 0);
      end
      start = 1'b1;
      check_burst(4, -1);
      chk("bound_empty", empty, 1);
      repeat (4 * CLK_DIV) begin
         tick();
         chk("bound_quiet_txd", TXD, 1);
      end
      start = 1'b0;
      tick();

      // start dropped mid-DATA of frame 1 of 3
      push_word(8'h5A);
      push_word(8'hC3);
      push_word(8'h96);
      start = 1'b1;
      check_burst(1, 4 * CLK_DIV);
      chk("drop_level", level, mcount);
      tick();
      chk("drop_stays_idle", busy, 0);

      // Reset mid-frame
      start = 1'b1;
      w = 0;
      while (TXD !== 1'b0 && w < 40) begin
         tick();
         w++;
      end
      chk("rst_mid_started", (w < 40) ? 1 : 0, 1);
      repeat (4 * CLK_DIV) tick();
      rst = 1'b0;
      sb.delete();
      mcount = 0;
      tick();
      chk("rstmid_txd", TXD, 1);
      chk("rstmid_rts", RTS, 0);
      chk("rstmid_level", level, 0);
      chk("rstmid_empty", empty, 1);
      chk("rstmid_uclk", usrt_clk_o, 0);
      rst   = 1'b1;
      start = 1'b0;
      tick();
      chk("rstmid_after_level", level, 0);

`ifdef USRT_TX_PARITY_EN
      // Parity even / odd on 0x07
      par_odd = 1'b0;
      push_word(8'h07);
      start = 1'b1;
      check_burst(1, -1);
      start = 1'b0;
      par_odd = 1'b1;
      push_word(8'h07);
      start = 1'b1;
      check_burst(1, -1);
      start = 1'b0;
      tick();
`endif

      // Randomized bursts
      for (int it = 0; it < 25; it++) begin
`ifdef USRT_TX_PARITY_EN
         par_odd = 1'($urandom_range(0, 1));
`endif
         nw = $urandom_range(1, FIFO_DEPTH + 2);
         for (int j = 0; j < nw; j++) push_word(DATA_W'($urandom));
         chk("rand_level", level, mcount);
         chk("rand_full", full, (mcount == FIFO_DEPTH) ? 1 : 0);
         extra = (mcount < FIFO_DEPTH) ? $urandom_range(0, 1) : 0;
         wat = (extra != 0) ? $urandom_range(1, mcount * FL * CLK_DIV) : -1;
         start = 1'b1;
         budget = (mcount + 2) * FL * CLK_DIV + 8 * CLK_DIV;
         c = 0;
         seen = 0;
         done = 0;
         while (c < budget && !done) begin
            if (c == wat) begin
               wr_data = DATA_W'($urandom);
               wr_en   = 1'b1;
               sb.push_back('{wr_data, cur_odd()});
            end
            tick();
            wr_en = 1'b0;
            c++;
            if (busy) seen = 1;
            else if (seen) done = 1;
         end
         chk("rand_drain_done", done, 1);
         chk("rand_empty", empty, 1);
         chk("rand_level0", level, 0);
         chk("rand_sb_drained", sb.size(), 0);
         start = 1'b0;
         mcount = 0;
         tick();
      end

      chk("final_sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
